vga_timing_gen: RTL

//  640x480@60 Hz VGA raster timing generator, single pixel_clk domain (25.175/25 MHz).

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_sync_delay.sv | 30 +++
 rtl/vga_timing_gen.sv | 80 ++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 Hz raster constants and decode helpers.
//   CNT_W          width of the horizontal/vertical counters
//   H_*/V_*        visible, front porch, sync and back porch lengths
//   H_MAX/V_MAX    last legal counter values (TOTAL-1)
//   HS_*/VS_*      inclusive sync windows
package vga_timing_pkg;
    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t H_VIS = 10'd640;
    localparam cnt_t H_FP  = 10'd16;
    localparam cnt_t H_SW  = 10'd96;
    localparam cnt_t H_BP  = 10'd48;
    localparam cnt_t V_VIS = 10'd480;
    localparam cnt_t V_FP  = 10'd10;
    localparam cnt_t V_SW  = 10'd2;
    localparam cnt_t V_BP  = 10'd33;
    localparam cnt_t H_TOTAL  = H_VIS + H_FP + H_SW + H_BP;
    localparam cnt_t V_TOTAL  = V_VIS + V_FP + V_SW + V_BP;
    localparam cnt_t H_MAX    = H_TOTAL - 10'd1;
    localparam cnt_t V_MAX    = V_TOTAL - 10'd1;
    localparam cnt_t HS_START = H_VIS + H_FP;
    localparam cnt_t HS_END   = H_VIS + H_FP + H_SW - 10'd1;
    localparam cnt_t VS_START = V_VIS + V_FP;
    localparam cnt_t VS_END   = V_VIS + V_FP + V_SW - 10'd1;

    function automatic logic in_range(cnt_t v, cnt_t lo, cnt_t hi);
        return (v >= lo) && (v <= hi);
    endfunction
endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: DLY-stage shift register with a per-bit reset vector.
//   clk_i   clock
//   rst_ni  async active-low reset, loads RST_VAL into every stage
//   d_i     W-bit input
//   q_o     d_i delayed DLY cycles (DLY=0: combinational pass-through)
module vga_sync_delay #(
    parameter int           W       = 3,
    parameter int           DLY     = 3,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    if (DLY == 0) begin : g_pass
        assign q_o = d_i;
    end else begin : g_dly
        logic [W-1:0] pipe_q [DLY];
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < DLY; i++) pipe_q[i] <= RST_VAL;
            end else begin
                pipe_q[0] <= d_i;
                for (int i = 1; i < DLY; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign q_o = pipe_q[DLY-1];
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA raster timing generator.
//   pixel_clk    pixel clock
//   rst_n        async active-low reset
//   pixel_x/y    raw horizontal/vertical counters (0..799 / 0..524)
//   video_on     inside the visible window, zero latency
//   frame_over   one-cycle tick at the last visible pixel (639,479)
//   VGA_HS/VS    syncs, delayed PIPE_DLY to match the colour pipeline
//   VGA_BLANK_N  video_on delayed PIPE_DLY
//   VGA_SYNC_N   tied low, no sync-on-green
//   frame_cnt    frame counter, present only with VGA_FRAME_CNT_EN defined
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   PIPE_DLY = 3,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             pixel_clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             video_on,
    output logic             frame_over,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_BLANK_N,
    output logic             VGA_SYNC_N
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);
    cnt_t h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic h_wrap, hs_raw, vs_raw;

    // Compares use >= so an out-of-range count falls back to 0 on the next edge.
    always_comb begin
        h_wrap  = h_cnt_q >= H_MAX;
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = (v_cnt_q > V_MAX || (h_wrap && v_cnt_q == V_MAX)) ? '0 : v_cnt_q + cnt_t'(h_wrap);
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign pixel_x    = h_cnt_q;
    assign pixel_y    = v_cnt_q;
    assign video_on   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign frame_over = (h_cnt_q == H_VIS - 10'd1) && (v_cnt_q == V_VIS - 10'd1);
    assign hs_raw     = in_range(h_cnt_q, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
    assign vs_raw     = in_range(v_cnt_q, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
    assign VGA_SYNC_N = 1'b0;

    // One shared delay line keeps HS, VS and BLANK_N mutually aligned.
    vga_sync_delay #(
        .W      (3),
        .DLY    (PIPE_DLY),
        .RST_VAL({~SYNC_POL, ~SYNC_POL, 1'b0})
    ) u_sync_dly (
        .clk_i (pixel_clk),
        .rst_ni(rst_n),
        .d_i   ({hs_raw, vs_raw, video_on}),
        .q_o   ({VGA_HS, VGA_VS, VGA_BLANK_N})
    );

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) frame_cnt_q <= '0;
        else if (frame_over) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
    assign frame_cnt = frame_cnt_q;
`endif
endmodule
